// File: rtl/rv32i_types.sv
// Shared types for the memory responder slice.
// Holds the responder FSM state enum, the default response latency,
// the latched request payload and a few width constants.
package rv32i_types;

    localparam int unsigned MEM_RESP_DEFAULT_LATENCY = 3;
    localparam int unsigned MEM_RESP_CNT_W           = 4;
    localparam int unsigned MEM_RESP_LANES           = 4;
    localparam int unsigned MEM_RESP_LANE_W          = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } mem_resp_state_t;

    // Request copy captured at acceptance
    typedef struct packed {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/mem_resp_array.sv
// Byte-enabled word array behind the memory responder.
// Ports:
//   clk       - rising-edge clock (write port only)
//   rd_index  - word index for the combinational read port
//   rd_data_c - word at rd_index
//   wr_en     - write strobe
//   wr_index  - word index for the write port
//   wr_be     - per-byte write enables, bit i selects byte i
//   wr_data   - write data
// Contents are never reset.
module mem_resp_array
    import rv32i_types::*;
#(
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] rd_index,
    output logic [31:0]       rd_data_c,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_index,
    input  logic [3:0]        wr_be,
    input  logic [31:0]       wr_data
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [31:0] mem [DEPTH];

    assign rd_data_c = mem[rd_index];

    // Byte-masked write; a zero mask leaves the word untouched
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < int'(MEM_RESP_LANES); i++) begin
                if (wr_be[i]) begin
                    mem[wr_index][MEM_RESP_LANE_W*i +: MEM_RESP_LANE_W] <=
                        wr_data[MEM_RESP_LANE_W*i +: MEM_RESP_LANE_W];
                end
            end
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency memory responder: accepts one read or write request,
// answers with a single-cycle mem_resp LATENCY cycles after acceptance.
// Ports:
//   clk, rst_n        - clock, asynchronous active-low reset
//   mem_read          - read request, held until mem_resp
//   mem_write         - write request, held until mem_resp
//   mem_address       - byte address, [1:0] ignored, wraps modulo array size
//   mem_byte_enable   - write lane enables
//   mem_wdata         - write data
//   mem_resp          - completion pulse
//   mem_rdata         - read data, held until the next read completes
//   proto_err         - sticky protocol-violation flag
// Optional feature: define MEM_RESP_PROTOCOL_CHECK_EN to build the
// protocol checker; otherwise proto_err is tied low.
module mem_responder
    import rv32i_types::*;
#(
    parameter int unsigned LATENCY = MEM_RESP_DEFAULT_LATENCY,
    parameter int unsigned ADDR_W  = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] mem_address,
    input  logic [3:0]  mem_byte_enable,
    input  logic [31:0] mem_wdata,
    output logic        mem_resp,
    output logic [31:0] mem_rdata,
    output logic        proto_err
);

    localparam int unsigned IDX_HI = ADDR_W + 1;

    mem_resp_state_t             state;
    mem_resp_state_t             next_state;
    logic [MEM_RESP_CNT_W-1:0]   cnt_q;
    mem_req_t                    req_q;

    logic              accept_c;
    logic              rd_load_c;
    logic              wr_en_c;
    logic [ADDR_W-1:0] rd_index_c;
    logic [31:0]       rd_data_c;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (mem_read || mem_write) begin
                    next_state = (LATENCY > 1) ? WAIT : RESP;
                end
            end
            WAIT: begin
                if (cnt_q == MEM_RESP_CNT_W'(1)) begin
                    next_state = RESP;
                end
            end
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Control outputs; on acceptance the live inputs steer the read since
    // the latched copy is not yet valid (matters when LATENCY is 1)
    always_comb begin
        accept_c   = 1'b0;
        rd_load_c  = 1'b0;
        wr_en_c    = 1'b0;
        rd_index_c = req_q.addr[IDX_HI:2];
        if (state == IDLE && (mem_read || mem_write)) begin
            accept_c   = 1'b1;
            rd_index_c = mem_address[IDX_HI:2];
        end
        if (next_state == RESP && state != RESP) begin
            rd_load_c = (state == IDLE) ? mem_read : req_q.rd;
        end
        wr_en_c = (state == RESP) && req_q.wr && !req_q.rd;
    end

    // Request latch, latency counter and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            req_q     <= '0;
            mem_resp  <= 1'b0;
            mem_rdata <= '0;
        end else begin
            mem_resp <= (next_state == RESP);
            if (accept_c) begin
                req_q <= '{rd:    mem_read,
                           wr:    mem_write,
                           addr:  mem_address,
                           be:    mem_byte_enable,
                           wdata: mem_wdata};
                cnt_q <= MEM_RESP_CNT_W'(LATENCY - 1);
            end else if (state == WAIT) begin
                cnt_q <= cnt_q - MEM_RESP_CNT_W'(1);
            end
            if (rd_load_c) begin
                mem_rdata <= rd_data_c;
            end
        end
    end

    mem_resp_array #(
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk       (clk),
        .rd_index  (rd_index_c),
        .rd_data_c (rd_data_c),
        .wr_en     (wr_en_c),
        .wr_index  (req_q.addr[IDX_HI:2]),
        .wr_be     (req_q.be),
        .wr_data   (req_q.wdata)
    );

`ifdef MEM_RESP_PROTOCOL_CHECK_EN
    logic perr_c;

    // Violation: both requests at acceptance, or any held input moving while waiting
    always_comb begin
        perr_c = 1'b0;
        if (accept_c && mem_read && mem_write) begin
            perr_c = 1'b1;
        end
        if (state == WAIT &&
            (mem_read        != req_q.rd   ||
             mem_write       != req_q.wr   ||
             mem_address     != req_q.addr ||
             mem_byte_enable != req_q.be   ||
             mem_wdata       != req_q.wdata)) begin
            perr_c = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            proto_err <= 1'b0;
        end else if (perr_c) begin
            proto_err <= 1'b1;
        end
    end
`else
    // Address bits outside the word index are only needed by the checker
    logic unused_addr_bits;
    assign unused_addr_bits = ^{req_q.addr[31:IDX_HI+1], req_q.addr[1:0]};
    assign proto_err        = 1'b0;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder at LATENCY=3, ADDR_W=10.
module tb_mem_responder;

    localparam int unsigned LAT    = 3;
    localparam int unsigned ADDR_W = 10;

`ifdef MEM_RESP_PROTOCOL_CHECK_EN
    localparam logic [31:0] EXP_PERR = 32'd1;
`else
    localparam logic [31:0] EXP_PERR = 32'd0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_address;
    logic [3:0]  mem_byte_enable;
    logic [31:0] mem_wdata;
    logic        mem_resp;
    logic [31:0] mem_rdata;
    logic        proto_err;

    int          vectors     = 0;
    int          miscompares = 0;
    logic [31:0] resp_data;
    int          seen;

    mem_responder #(
        .LATENCY (LAT),
        .ADDR_W  (ADDR_W)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_address     (mem_address),
        .mem_byte_enable (mem_byte_enable),
        .mem_wdata       (mem_wdata),
        .mem_resp        (mem_resp),
        .mem_rdata       (mem_rdata),
        .proto_err       (proto_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive a request at a falling edge, wait (bounded) for mem_resp,
    // check the cycle count, capture rdata and drop the request.
    task automatic xact(input string tag, input logic rd, input logic wr,
                        input logic [31:0] addr, input logic [3:0] be,
                        input logic [31:0] wd, input int exp_cycles);
        int k;
        k               = 0;
        mem_read        = rd;
        mem_write       = wr;
        mem_address     = addr;
        mem_byte_enable = be;
        mem_wdata       = wd;
        do begin
            @(negedge clk);
            k++;
        end while (mem_resp !== 1'b1 && k < 20);
        resp_data = mem_rdata;
        check({tag, "_lat"}, 32'(k), 32'(exp_cycles));
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        mem_address     = 32'h0;
        mem_byte_enable = 4'h0;
        mem_wdata       = 32'h0;
    endtask

    task automatic idle_cycle(input string tag);
        @(negedge clk);
        check({tag, "_pulse"}, 32'(mem_resp), 32'd0);
    endtask

    initial begin
        rst_n           = 1'b0;
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        mem_address     = 32'h0;
        mem_byte_enable = 4'h0;
        mem_wdata       = 32'h0;
        repeat (2) @(negedge clk);
        check("rst_resp",  32'(mem_resp),  32'd0);
        check("rst_rdata", mem_rdata,      32'h0);
        check("rst_perr",  32'(proto_err), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Full-word write, then read back
        xact("wr_full", 1'b0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, LAT);
        idle_cycle("wr_full");
        check("wr_keeps_rdata", mem_rdata, 32'h0);
        xact("rd_full", 1'b1, 1'b0, 32'h10, 4'h0, 32'h0, LAT);
        check("rd_full_data", resp_data, 32'hDEADBEEF);
        idle_cycle("rd_full");

        // Byte-0 write followed back-to-back by a read
        xact("wr_byte0", 1'b0, 1'b1, 32'h10, 4'b0001, 32'h000000AA, LAT);
        xact("rd_b2b",   1'b1, 1'b0, 32'h10, 4'h0,    32'h0,        LAT + 1);
        check("rd_b2b_data", resp_data, 32'hDEADBEAA);
        idle_cycle("rd_b2b");

        // Zero byte-enable write is a no-op; rdata held across it
        xact("wr_be0", 1'b0, 1'b1, 32'h10, 4'b0000, 32'h12345678, LAT);
        idle_cycle("wr_be0");
        check("rdata_hold", mem_rdata, 32'hDEADBEAA);
        xact("rd_be0", 1'b1, 1'b0, 32'h10, 4'h0, 32'h0, LAT);
        check("rd_be0_data", resp_data, 32'hDEADBEAA);
        idle_cycle("rd_be0");

        // Aliasing above the index and ignored low address bits
        xact("wr_alias", 1'b0, 1'b1, 32'h00001010, 4'hF, 32'hCAFEF00D, LAT);
        idle_cycle("wr_alias");
        xact("rd_alias", 1'b1, 1'b0, 32'h00000010, 4'h0, 32'h0, LAT);
        check("rd_alias_data", resp_data, 32'hCAFEF00D);
        idle_cycle("rd_alias");
        xact("rd_lowbits", 1'b1, 1'b0, 32'h00000013, 4'h0, 32'h0, LAT);
        check("rd_lowbits_data", resp_data, 32'hCAFEF00D);
        idle_cycle("rd_lowbits");

        // Top word, mixed lane mask
        xact("wr_top", 1'b0, 1'b1, 32'h00000FFC, 4'hF, 32'h11223344, LAT);
        idle_cycle("wr_top");
        xact("wr_top_mask", 1'b0, 1'b1, 32'h00000FFC, 4'b1010, 32'hAABBCCDD, LAT);
        idle_cycle("wr_top_mask");
        xact("rd_top", 1'b1, 1'b0, 32'h00000FFC, 4'h0, 32'h0, LAT);
        check("rd_top_data", resp_data, 32'hAA22CC44);
        idle_cycle("rd_top");
        check("perr_clean", 32'(proto_err), 32'd0);

        // Read and write together: read only, array untouched
        xact("rd_wr_both", 1'b1, 1'b1, 32'h10, 4'hF, 32'h0, LAT);
        check("rd_wr_both_data", resp_data, 32'hCAFEF00D);
        idle_cycle("rd_wr_both");
        check("perr_both", 32'(proto_err), EXP_PERR);
        xact("rd_after_both", 1'b1, 1'b0, 32'h10, 4'h0, 32'h0, LAT);
        check("rd_after_both_data", resp_data, 32'hCAFEF00D);
        idle_cycle("rd_after_both");
        check("perr_sticky", 32'(proto_err), EXP_PERR);

        // Reset during WAIT aborts the write
        mem_write       = 1'b1;
        mem_address     = 32'h10;
        mem_byte_enable = 4'hF;
        mem_wdata       = 32'h0BADF00D;
        @(posedge clk);
        @(negedge clk);
        rst_n           = 1'b0;
        mem_write       = 1'b0;
        mem_address     = 32'h0;
        mem_byte_enable = 4'h0;
        mem_wdata       = 32'h0;
        seen            = 0;
        repeat (6) begin
            @(negedge clk);
            if (mem_resp !== 1'b0) seen++;
        end
        check("abort_no_resp", 32'(seen),      32'd0);
        check("abort_rdata",   mem_rdata,      32'h0);
        check("abort_perr",    32'(proto_err), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        xact("rd_after_abort", 1'b1, 1'b0, 32'h10, 4'h0, 32'h0, LAT);
        check("rd_after_abort_data", resp_data, 32'hCAFEF00D);
        idle_cycle("rd_after_abort");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
